// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and enums for the VRAM arbiter slice.
//   VRAM_ADDR_W / VRAM_DATA_W : default character-RAM geometry (2K x 8)
//   host_state_t              : host read FSM states (IDLE, PEND, WAIT)
//   grant_t                   : which requester owns the SRAM this cycle
package vga_pkg;
    localparam int VRAM_ADDR_W = 11;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, PEND, WAIT} host_state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_DISP, GNT_WR, GNT_RD} grant_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the display fetch port, the host request port and
// the synchronous single-port SRAM port of the VRAM arbiter.
//   master : requester/memory side (display, host, SRAM model)
//   slave  : the arbiter itself
interface vram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    // display fetch
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;
    // host requests
    logic              h_valid;
    logic              h_ready;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic [DATA_W-1:0] h_rdata;
    logic              h_rvalid;
    // SRAM
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport master (
        output disp_req, disp_addr, h_valid, h_we, h_addr, h_wdata, sram_rdata,
        input  disp_rdata, disp_rvalid, h_ready, h_rdata, h_rvalid,
               sram_addr, sram_we, sram_wdata
    );

    modport slave (
        input  disp_req, disp_addr, h_valid, h_we, h_addr, h_wdata, sram_rdata,
        output disp_rdata, disp_rvalid, h_ready, h_rdata, h_rvalid,
               sram_addr, sram_we, sram_wdata
    );
endinterface

// File: rtl/vram_wfifo.sv
// vram_wfifo: synchronous FIFO of posted host writes ({addr,data} words).
//   clk, reset          : clock, async active-high reset (empties the FIFO)
//   push, push_data     : enqueue (ignored when full)
//   pop, pop_data       : dequeue (ignored when empty); pop_data shows the head
//   full, empty         : derived from pointers only, so a pop never frees
//                         space for a push in the same cycle
// DEPTH must be a power of two (2..16); pointers carry one extra wrap bit.
module vram_wfifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous single-port VRAM between the display
// fetcher (fixed 2-cycle latency, never stalled) and a host port with posted
// writes and a single outstanding read.
//   clk, reset  : clock, async active-high reset
//   bus         : vram_arbiter_if.slave (display, host, SRAM ports)
//   stall_count : only with VRAM_ARB_STATS_EN defined; saturating count of
//                 cycles where pending host work lost the SRAM to the display
// Grant priority each cycle: display > queued write > pending host read.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W      = VRAM_ADDR_W,
    parameter int DATA_W      = VRAM_DATA_W,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    vram_arbiter_if.slave      bus
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]        stall_count
`endif
);
    host_state_t       state, state_nxt;
    grant_t            gnt;
    logic              fifo_full, fifo_empty;
    logic              wr_acc, rd_acc;
    logic [ADDR_W-1:0] fifo_addr, rd_addr;
    logic [DATA_W-1:0] fifo_data;
    logic [1:0]        disp_vld_pipe;  // [0]: SRAM read in flight, [1]: rvalid
    logic [DATA_W-1:0] disp_rdata_q, h_rdata_q;
    logic              h_rvalid_q;

    assign wr_acc = bus.h_valid && bus.h_ready &&  bus.h_we;
    assign rd_acc = bus.h_valid && bus.h_ready && !bus.h_we;

    vram_wfifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_acc),
        .push_data ({bus.h_addr, bus.h_wdata}),
        .pop       (gnt == GNT_WR),
        .pop_data  ({fifo_addr, fifo_data}),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // host read FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // host read FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_acc)         state_nxt = PEND;
            PEND:    if (gnt == GNT_RD)  state_nxt = WAIT;
            WAIT:                        state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // host read FSM / arbiter: outputs. Reads wait for an empty FIFO so a
    // read can never overtake an earlier posted write.
    always_comb begin
        gnt            = GNT_NONE;
        bus.h_ready    = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_we    = 1'b0;
        bus.sram_wdata = '0;
        if (!reset) begin
            if (state == IDLE)
                bus.h_ready = bus.h_we ? !fifo_full : fifo_empty;
            if (bus.disp_req)      gnt = GNT_DISP;
            else if (!fifo_empty)  gnt = GNT_WR;
            else if (state == PEND) gnt = GNT_RD;
        end
        case (gnt)
            GNT_DISP: bus.sram_addr = bus.disp_addr;
            GNT_WR: begin
                bus.sram_addr  = fifo_addr;
                bus.sram_we    = 1'b1;
                bus.sram_wdata = fifo_data;
            end
            GNT_RD:   bus.sram_addr = rd_addr;
            default:  bus.sram_addr = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr       <= '0;
            disp_vld_pipe <= '0;
            disp_rdata_q  <= '0;
            h_rdata_q     <= '0;
            h_rvalid_q    <= 1'b0;
        end else begin
            if (rd_acc) rd_addr <= bus.h_addr;
            disp_vld_pipe <= {disp_vld_pipe[0], gnt == GNT_DISP};
            if (disp_vld_pipe[0]) disp_rdata_q <= bus.sram_rdata;
            h_rvalid_q <= (state == WAIT);
            if (state == WAIT) h_rdata_q <= bus.sram_rdata;
        end
    end

    assign bus.disp_rvalid = disp_vld_pipe[1];
    assign bus.disp_rdata  = disp_rdata_q;
    assign bus.h_rvalid    = h_rvalid_q;
    assign bus.h_rdata     = h_rdata_q;

`ifdef VRAM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (bus.disp_req && (!fifo_empty || state == PEND) &&
                 stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif
endmodule
